// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing in-order fetches, buffering instructions for decode, handling redirects
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
   state_e          state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redir_pc;
   logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d, cnt_q, cnt_d;
   logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [31:0]     instr_q [FIFO_DEPTH];
   logic [31:0]     pc_q [FIFO_DEPTH];
   logic            credit_ok, req_fire, push, pop;
   // Requests in flight plus buffered entries never exceed the buffer, so no response can overflow it
   assign credit_ok      = ({1'b0, outst_q} + {1'b0, cnt_q}) < (CW+1)'(FIFO_DEPTH);
   assign imem_req_valid = (state_q == RUN) && credit_ok && !redirect_valid;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign if_valid       = cnt_q != '0;
   assign pop            = if_valid && if_ready && !redirect_valid;
   assign push           = imem_resp_valid && drop_q == '0 && !redirect_valid;
   assign if_instr       = if_valid ? instr_q[rd_q] : '0;
   assign if_pc          = if_valid ? pc_q[rd_q] : '0;
   assign if_pc_plus4    = if_pc + 32'd4;
   assign redir_pc       = redirect_pc & ~32'd3;
   // Next-state: normal fetch/response/pop bookkeeping, overridden wholesale by a redirect
   always_comb begin
      fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
      resp_pc_d  = push ? resp_pc_q + 32'd4 : resp_pc_q;
      outst_d    = outst_q + CW'(req_fire) - CW'(imem_resp_valid);
      drop_d     = (imem_resp_valid && drop_q != '0) ? drop_q - 1'b1 : drop_q;
      cnt_d      = cnt_q + CW'(push) - CW'(pop);
      wr_d       = push ? wr_q + 1'b1 : wr_q;
      rd_d       = pop ? rd_q + 1'b1 : rd_q;
      if (redirect_valid) begin
         fetch_pc_d = redir_pc;
         resp_pc_d  = redir_pc;
         drop_d     = outst_q - CW'(imem_resp_valid);
         cnt_d      = '0;
         wr_d       = '0;
         rd_d       = '0;
      end
      state_d = (state_q == IDLE || drop_d == '0) ? RUN : DRAIN;
   end
   // State and control registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
         cnt_q      <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         cnt_q      <= cnt_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
      end
   end
   // Buffer storage; contents are only visible through the occupancy count, so no reset is needed
   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[wr_q] <= imem_resp_data;
         pc_q[wr_q]    <= resp_pc_q;
      end
   end
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && !pop && cnt_q == CW'(FIFO_DEPTH)));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(imem_resp_valid && outst_q == '0));
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage upstream of the cpu decode/register-file path.
- Owns the PC and issues in-order word requests to instruction memory through a valid/ready request channel.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Handles branch/jump redirects by flushing the buffer and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the cap on outstanding requests plus buffered entries (power of 2, ≥2).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; asserted while 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  response data valid; responses return in order, ≥1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  taken branch/jump from the downstream stage.
- redirect_pc  in  32  new PC; bits [1:0] are ignored and treated as 0.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode consumes the head entry.
- if_instr  out  32  head instruction.
- if_pc  out  32  PC of the head instruction.
- if_pc_plus4  out  32  if_pc + 4, mod 2^32.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; fetch_pc=RESET_PC; resp_pc=RESET_PC.
  - outstanding=0; drop_cnt=0; FIFO empty.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=4.
- Reset asserted mid-operation: all in-flight requests are forgotten. Memory is reset with the same rst, so no stale responses arrive.
- States:
  - IDLE: no requests. Unconditionally moves to RUN on the first clock edge after rst deasserts.
  - RUN: imem_req_valid = (outstanding + fifo_count < FIFO_DEPTH) && !redirect_valid.
  - DRAIN: imem_req_valid=0. Moves to RUN in the cycle drop_cnt reaches 0.
- imem_req_addr = fetch_pc whenever imem_req_valid=1.
- Request accepted (valid && ready): fetch_pc += 4 (wraps mod 2^32); outstanding += 1.
- Request handshake rules:
  - Once valid=1 with ready=0, valid and addr hold stable next cycle.
  - Only exception: redirect_valid, which may withdraw the request.
- Response handling (imem_resp_valid=1): outstanding -= 1.
  - If drop_cnt>0: data discarded; drop_cnt -= 1.
  - Else: {resp_pc, data} written to the FIFO tail; resp_pc += 4.
  - The credit rule guarantees the FIFO never overflows; a write into a full FIFO is an assertion failure.
- Output latency: a request accepted at cycle N with a response at N+k makes if_valid=1 from cycle N+k+1. The FIFO is registered; there is no response-to-output bypass.
- Decode side:
  - if_valid = FIFO non-empty; head fields drive if_instr/if_pc/if_pc_plus4.
  - Fields are 0 (if_pc_plus4=4) when empty.
  - Pop on if_valid && if_ready. Simultaneous push and pop on a full FIFO is legal.
- Redirect (redirect_valid=1) has highest priority in its cycle:
  - FIFO flushed; any same-cycle pop is ignored.
  - fetch_pc and resp_pc set to {redirect_pc[31:2],2'b00}.
  - No request issued that cycle.
  - drop_cnt = outstanding − (imem_resp_valid ? 1 : 0) + existing drop_cnt adjustment. Net effect: every response for a request accepted before the redirect edge is dropped, including the one arriving in the redirect cycle.
  - Next state: DRAIN if the new drop_cnt>0, else RUN.
- Redirect while in DRAIN: handled the same way; drop_cnt continues to count all remaining in-flight responses.
- Redirect while in IDLE: PCs are updated; the state still goes to RUN.
- Counters: outstanding and drop_cnt are clog2(FIFO_DEPTH)+1 bits wide. Underflow is an assertion failure.

Test Plan:
- Reset with RESET_PC=32'h0000_0040, memory responding in 1 cycle, if_ready=1 → addresses 0x40, 0x44, 0x48…; if_valid first high 2 cycles after the first accept; if_pc/if_instr sequence matches memory; if_pc_plus4=0x44 for the first entry.
- if_ready=0 for 10 cycles → exactly FIFO_DEPTH=2 requests issued, then imem_req_valid=0. Raising if_ready pops 0x40, then 0x44 on consecutive cycles, and fetching resumes at 0x48.
- imem_req_ready=0 for 3 cycles with valid high → imem_req_valid/imem_req_addr=0x40 held stable; fetch_pc is unchanged until accepted.
- Memory latency 3, redirect_valid to 0x100 with 2 requests in flight → both responses dropped, state DRAIN for 2 responses; the next if_pc is 0x100 with its correct instruction; no stale word reaches decode.
- Redirect in the same cycle as a response and a decode pop, with 1 in flight → the response is dropped, the FIFO is empty next cycle, state RUN, and a request to the redirect PC is issued the following cycle.
- rst pulsed low for 1 cycle mid-stream (asynchronous, between edges) → outputs return to reset values immediately; after release, fetch restarts at RESET_PC with no leftover entries.
